// File: rtl/ife_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ife_block_scheduler
// Description : Gathers fetched instructions into blocks. Each block goes out
//               in one parallel beat if the dependence checker marks it safe,
//               and one instruction per beat if it does not.
// Revision    : 1.0 - initial release
// ============================================================================
module ife_block_scheduler #(
    parameter int INSTR_WIDTH   = 32,
    parameter int BLOCK_SIZE    = 4,
    parameter int FLUSH_TIMEOUT = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic [INSTR_WIDTH-1:0]            in_instr,
    output logic                              in_ready,
    input  logic                              flush,
    output logic [BLOCK_SIZE*INSTR_WIDTH-1:0] chk_instrs,
    output logic [BLOCK_SIZE-1:0]             chk_valid,
    input  logic                              chk_is_safe,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BLOCK_SIZE*INSTR_WIDTH-1:0] out_instrs,
    output logic [BLOCK_SIZE-1:0]             out_lanes_valid,
    output logic                              out_parallel,
    output logic                              busy
);

    localparam int CW = $clog2(BLOCK_SIZE + 1);
    localparam int PW = $clog2(BLOCK_SIZE);
    localparam int IW = $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [CW-1:0]         C_CNT_LAST  = CW'(BLOCK_SIZE - 1);
    localparam logic [IW-1:0]         C_IDLE_LAST = IW'(FLUSH_TIMEOUT - 1);
    localparam logic [IW-1:0]         C_IDLE_MAX  = IW'(FLUSH_TIMEOUT);
    localparam logic [BLOCK_SIZE-1:0] C_LANE0     = BLOCK_SIZE'(1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_CHECK = 2'd1,
        S_PAR   = 2'd2,
        S_SER   = 2'd3
    } state_t;

    state_t                                  r_state;
    logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0]  r_buf;
    logic [BLOCK_SIZE-1:0]                   r_mask;
    logic [CW-1:0]                           r_cnt;
    logic [IW-1:0]                           r_idle;
    logic [PW-1:0]                           r_ptr;
    logic                                    r_mode;
    logic                                    r_out_valid;
    logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0]  r_out_instrs;
    logic [BLOCK_SIZE-1:0]                   r_out_lanes;

    logic                   w_accept;
    logic                   w_close;
    logic                   w_ser_last;
    logic                   w_done;
    logic [PW-1:0]          w_ptr_next;
    logic [INSTR_WIDTH-1:0] w_next_instr;

    assign w_accept = (r_state == S_FILL) && in_valid;

    // Block closes when full, on flush with something to send, or after the
    // idle window expires with a partial block sitting in the buffer.
    assign w_close = (w_accept && (r_cnt == C_CNT_LAST))
                  || (flush && ((r_cnt != '0) || w_accept))
                  || (!w_accept && (r_cnt != '0) && (r_idle == C_IDLE_LAST));

    assign w_ptr_next = r_ptr + PW'(1);
    assign w_ser_last = ((CW'(r_ptr) + CW'(1)) == r_cnt);
    assign w_done     = out_ready && ((r_state == S_PAR) || ((r_state == S_SER) && w_ser_last));

    always_comb begin
        w_next_instr = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (w_ptr_next == PW'(i)) begin
                w_next_instr = r_buf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FILL;
            r_buf        <= '0;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_idle       <= '0;
            r_ptr        <= '0;
            r_mode       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_instrs <= '0;
            r_out_lanes  <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        for (int i = 0; i < BLOCK_SIZE; i++) begin
                            if (r_cnt == CW'(i)) begin
                                r_buf[i]  <= in_instr;
                                r_mask[i] <= 1'b1;
                            end
                        end
                        r_cnt  <= r_cnt + CW'(1);
                        r_idle <= '0;
                    end else if ((r_cnt != '0) && (r_idle != C_IDLE_MAX)) begin
                        r_idle <= r_idle + IW'(1);
                    end
                    if (w_close) begin
                        r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    r_mode      <= chk_is_safe;
                    r_ptr       <= '0;
                    r_out_valid <= 1'b1;
                    if (chk_is_safe) begin
                        r_out_instrs <= r_buf;
                        r_out_lanes  <= r_mask;
                        r_state      <= S_PAR;
                    end else begin
                        r_out_instrs    <= '0;
                        r_out_instrs[0] <= r_buf[0];
                        r_out_lanes     <= C_LANE0;
                        r_state         <= S_SER;
                    end
                end

                S_PAR, S_SER: begin
                    if (w_done) begin
                        r_state      <= S_FILL;
                        r_buf        <= '0;
                        r_mask       <= '0;
                        r_cnt        <= '0;
                        r_idle       <= '0;
                        r_ptr        <= '0;
                        r_mode       <= 1'b0;
                        r_out_valid  <= 1'b0;
                        r_out_instrs <= '0;
                        r_out_lanes  <= '0;
                    end else if ((r_state == S_SER) && out_ready) begin
                        // Lane 0 walks through the buffered slots in order.
                        r_ptr           <= w_ptr_next;
                        r_out_instrs[0] <= w_next_instr;
                    end
                end

                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign in_ready        = rst_n && (r_state == S_FILL);
    assign chk_instrs      = r_buf;
    assign chk_valid       = r_mask;
    assign out_valid       = r_out_valid;
    assign out_instrs      = r_out_instrs;
    assign out_lanes_valid = r_out_lanes;
    assign out_parallel    = r_mode;
    assign busy            = (r_state != S_FILL) || (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_ife_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ife_block_scheduler
// Description : Directed scenarios plus a random run against a block-level
//               reference model with an RV32 register-hazard checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ife_block_scheduler;

    localparam int W  = 32;
    localparam int BS = 4;
    localparam int FT = 8;

    typedef struct packed {
        logic [BS-1:0][W-1:0] instrs;
        logic [BS-1:0]        lanes;
        logic                 par;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid, flush, out_ready, chk_is_safe;
    logic [W-1:0]      in_instr;
    logic              in_ready, out_valid, out_parallel, busy;
    logic [BS*W-1:0]   chk_instrs, out_instrs;
    logic [BS-1:0]     chk_valid, out_lanes_valid;

    logic              in1_valid, flush1, out1_ready, chk1_is_safe;
    logic [W-1:0]      in1_instr;
    logic              in1_ready, out1_valid, out1_parallel, busy1;
    logic [BS*W-1:0]   chk1_instrs, out1_instrs;
    logic [BS-1:0]     chk1_valid, out1_lanes_valid;

    int checks = 0;
    int errors = 0;

    logic [BS-1:0][W-1:0] indep, raw, e;

    ife_block_scheduler #(.INSTR_WIDTH(W), .BLOCK_SIZE(BS), .FLUSH_TIMEOUT(FT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .chk_instrs(chk_instrs),
        .chk_valid(chk_valid), .chk_is_safe(chk_is_safe), .out_valid(out_valid),
        .out_ready(out_ready), .out_instrs(out_instrs),
        .out_lanes_valid(out_lanes_valid), .out_parallel(out_parallel), .busy(busy)
    );

    ife_block_scheduler #(.INSTR_WIDTH(W), .BLOCK_SIZE(BS), .FLUSH_TIMEOUT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in1_valid), .in_instr(in1_instr),
        .in_ready(in1_ready), .flush(flush1), .chk_instrs(chk1_instrs),
        .chk_valid(chk1_valid), .chk_is_safe(chk1_is_safe), .out_valid(out1_valid),
        .out_ready(out1_ready), .out_instrs(out1_instrs),
        .out_lanes_valid(out1_lanes_valid), .out_parallel(out1_parallel), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Safe = no RAW, WAW or WAR register overlap between any two valid lanes.
    function automatic bit blk_safe(input logic [BS-1:0][W-1:0] ins, input logic [BS-1:0] v);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < BS; i++) begin
            for (int j = i + 1; j < BS; j++) begin
                if (v[i] && v[j]) begin
                    if (ins[i][11:7] != 5'd0 && (ins[i][11:7] == ins[j][19:15] ||
                        ins[i][11:7] == ins[j][24:20] || ins[i][11:7] == ins[j][11:7]))
                        ok = 1'b0;
                    if (ins[j][11:7] != 5'd0 && (ins[j][11:7] == ins[i][19:15] ||
                        ins[j][11:7] == ins[i][24:20]))
                        ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    always_comb chk_is_safe  = blk_safe(chk_instrs, chk_valid);
    always_comb chk1_is_safe = blk_safe(chk1_instrs, chk1_valid);

    function automatic logic [W-1:0] rand_instr();
        return {7'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                3'b0, 5'($urandom_range(0, 31)), 7'b0110011};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [BS-1:0][W-1:0] blk, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_instr = blk[i];
            cyc();
        end
        in_valid = 1'b0;
        in_instr = '0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; flush = 1'b1; in_instr = 32'h003100B3;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (chk_valid !== 4'b0) begin errors++; $display("FAIL rst_chk_valid got %b exp 0", chk_valid); end
        checks++; if (out_lanes_valid !== 4'b0 || out_parallel !== 1'b0) begin errors++;
            $display("FAIL rst_out_lanes got %b/%b exp 0000/0", out_lanes_valid, out_parallel); end
        cyc();
        in_valid = 1'b0; flush = 1'b0;
        rst_n = 1'b1;
        cyc();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b exp 0", busy); end
    endtask

    task automatic test_parallel();
        out_ready = 1'b1;
        push(indep, 4);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++;
            $display("FAIL par_check_cycle got valid %b ready %b exp 0 0", out_valid, in_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL par_busy got %b exp 1", busy); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_parallel !== 1'b1) begin errors++;
            $display("FAIL par_beat got valid %b par %b exp 1 1", out_valid, out_parallel); end
        checks++; if (out_lanes_valid !== 4'b1111) begin errors++; $display("FAIL par_lanes got %b exp 1111", out_lanes_valid); end
        checks++; if (out_instrs !== indep) begin errors++; $display("FAIL par_instrs got %h exp %h", out_instrs, indep); end
        cyc();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL par_done got valid %b ready %b busy %b exp 0 1 0", out_valid, in_ready, busy); end
    endtask

    task automatic test_serial();
        out_ready = 1'b1;
        push(raw, 4);
        cyc();
        for (int k = 0; k < 4; k++) begin
            e = '0; e[0] = raw[k];
            checks++; if (out_valid !== 1'b1 || out_parallel !== 1'b0 || out_lanes_valid !== 4'b0001) begin errors++;
                $display("FAIL ser_beat%0d got valid %b par %b lanes %b exp 1 0 0001", k, out_valid, out_parallel, out_lanes_valid); end
            checks++; if (out_instrs !== e) begin errors++; $display("FAIL ser_instr%0d got %h exp %h", k, out_instrs, e); end
            cyc();
        end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL ser_done got valid %b ready %b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic test_partial_flush();
        out_ready = 1'b1;
        push(indep, 2);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++;
            $display("FAIL flush_check got valid %b ready %b exp 0 0", out_valid, in_ready); end
        cyc();
        e = '0; e[0] = indep[0]; e[1] = indep[1];
        checks++; if (out_valid !== 1'b1 || out_parallel !== 1'b1 || out_lanes_valid !== 4'b0011) begin errors++;
            $display("FAIL flush_beat got valid %b par %b lanes %b exp 1 1 0011", out_valid, out_parallel, out_lanes_valid); end
        checks++; if (out_instrs !== e) begin errors++; $display("FAIL flush_instrs got %h exp %h", out_instrs, e); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_beat got %b exp 0", out_valid); end
        flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++;
                $display("FAIL flush_empty%0d got valid %b busy %b ready %b exp 0 0 1", k, out_valid, busy, in_ready); end
        end
        flush = 1'b0;
    endtask

    task automatic test_timeout();
        out_ready = 1'b1;
        push(indep, 1);
        for (int k = 0; k <= FT; k++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tmo_early%0d got %b exp 0", k, out_valid); end
            cyc();
        end
        e = '0; e[0] = indep[0];
        checks++; if (out_valid !== 1'b1 || out_lanes_valid !== 4'b0001 || out_instrs !== e) begin errors++;
            $display("FAIL tmo_beat got valid %b lanes %b instrs %h exp 1 0001 %h", out_valid, out_lanes_valid, out_instrs, e); end
        cyc();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL tmo_done got valid %b busy %b exp 0 0", out_valid, busy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push(indep, 4);
        cyc();
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || out_parallel !== 1'b1 || out_instrs !== indep || in_ready !== 1'b0) begin errors++;
                $display("FAIL bp_par%0d got valid %b par %b ready %b instrs %h exp 1 1 0 %h", k, out_valid, out_parallel, in_ready, out_instrs, indep); end
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL bp_par_done got valid %b ready %b exp 0 1", out_valid, in_ready); end
        out_ready = 1'b0;
        push(raw, 4);
        cyc();
        e = '0; e[0] = raw[0];
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || out_lanes_valid !== 4'b0001 || out_instrs !== e || in_ready !== 1'b0) begin errors++;
                $display("FAIL bp_ser%0d got valid %b lanes %b ready %b instrs %h exp 1 0001 0 %h", k, out_valid, out_lanes_valid, in_ready, out_instrs, e); end
            cyc();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = '0; e[0] = raw[k];
            checks++; if (out_valid !== 1'b1 || out_instrs !== e) begin errors++;
                $display("FAIL bp_ser_resume%0d got valid %b instrs %h exp 1 %h", k, out_valid, out_instrs, e); end
            cyc();
        end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL bp_ser_done got valid %b busy %b exp 0 0", out_valid, busy); end
    endtask

    task automatic test_reset_mid_ser();
        out_ready = 1'b1;
        push(raw, 4);
        cyc();
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || chk_valid !== 4'b0) begin errors++;
            $display("FAIL midrst got valid %b busy %b ready %b mask %b exp 0 0 0 0000", out_valid, busy, in_ready, chk_valid); end
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL midrst_after got valid %b busy %b exp 0 0", out_valid, busy); end
        push(indep, 4);
        cyc();
        checks++; if (out_valid !== 1'b1 || out_parallel !== 1'b1 || out_instrs !== indep) begin errors++;
            $display("FAIL midrst_next got valid %b par %b instrs %h exp 1 1 %h", out_valid, out_parallel, out_instrs, indep); end
        cyc();
    endtask

    task automatic test_timeout_one();
        in1_valid = 1'b1;
        in1_instr = indep[2];
        cyc();
        in1_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL tmo1_early%0d got %b exp 0", k, out1_valid); end
            cyc();
        end
        e = '0; e[0] = indep[2];
        checks++; if (out1_valid !== 1'b1 || out1_lanes_valid !== 4'b0001 || out1_instrs !== e) begin errors++;
            $display("FAIL tmo1_beat got valid %b lanes %b instrs %h exp 1 0001 %h", out1_valid, out1_lanes_valid, out1_instrs, e); end
        cyc();
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL tmo1_done got %b exp 0", out1_valid); end
    endtask

    task automatic test_random();
        logic [W-1:0]         pend[$];
        beat_t                beats[$];
        beat_t                b;
        logic [BS-1:0][W-1:0] blk;
        logic [BS-1:0]        msk;
        int                   idle;
        bit                   chk_wait, acc, exp_ready, exp_valid, exp_busy;
        int                   pv;
        idle = 0; chk_wait = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            blk = '0; msk = '0;
            foreach (pend[i]) begin blk[i] = pend[i]; msk[i] = 1'b1; end
            exp_ready = !(chk_wait || beats.size() > 0);
            exp_valid = beats.size() > 0 && !chk_wait;
            exp_busy  = chk_wait || beats.size() > 0 || pend.size() > 0;
            checks++; if (in_ready !== exp_ready || out_valid !== exp_valid || busy !== exp_busy) begin errors++;
                $display("FAIL rnd_ctrl c%0d got ready %b valid %b busy %b exp %b %b %b", c, in_ready, out_valid, busy, exp_ready, exp_valid, exp_busy); end
            checks++; if (chk_valid !== msk || chk_instrs !== blk) begin errors++;
                $display("FAIL rnd_chk c%0d got %b %h exp %b %h", c, chk_valid, chk_instrs, msk, blk); end
            if (exp_valid) begin
                checks++; if (out_instrs !== beats[0].instrs || out_lanes_valid !== beats[0].lanes || out_parallel !== beats[0].par) begin errors++;
                    $display("FAIL rnd_beat c%0d got %h %b %b exp %h %b %b", c, out_instrs, out_lanes_valid, out_parallel,
                             beats[0].instrs, beats[0].lanes, beats[0].par); end
            end
            if (errors > 20) break;
            pv        = (c < 750) ? 70 : 12;
            in_valid  = ($urandom_range(0, 99) < pv);
            in_instr  = rand_instr();
            flush     = ($urandom_range(0, 99) < 4);
            out_ready = ($urandom_range(0, 99) < 70);
            if (chk_wait) begin
                chk_wait = 1'b0;
            end else if (beats.size() > 0) begin
                if (out_ready) begin
                    void'(beats.pop_front());
                    if (beats.size() == 0) begin pend.delete(); idle = 0; end
                end
            end else begin
                acc = in_valid;
                if (acc) begin pend.push_back(in_instr); idle = 0; end
                else if (pend.size() > 0) idle++;
                if ((acc && pend.size() == BS) || (flush && pend.size() > 0) ||
                    (!acc && pend.size() > 0 && idle == FT)) begin
                    chk_wait = 1'b1;
                    blk = '0; msk = '0;
                    foreach (pend[i]) begin blk[i] = pend[i]; msk[i] = 1'b1; end
                    if (blk_safe(blk, msk)) begin
                        b.instrs = blk; b.lanes = msk; b.par = 1'b1;
                        beats.push_back(b);
                    end else begin
                        foreach (pend[i]) begin
                            b.instrs = '0; b.instrs[0] = pend[i]; b.lanes = 4'b0001; b.par = 1'b0;
                            beats.push_back(b);
                        end
                    end
                end
            end
            cyc();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (30) cyc();
    endtask

    initial begin
        indep = {32'h00C58533, 32'h009403B3, 32'h00628233, 32'h003100B3};
        raw   = {32'h00C58533, 32'h009403B3, 32'h002082B3, 32'h003100B3};
        in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
        in1_valid = 1'b0; in1_instr = '0; flush1 = 1'b0; out1_ready = 1'b1;
        test_reset();
        test_parallel();
        test_serial();
        test_partial_flush();
        test_timeout();
        test_backpressure();
        test_reset_mid_ser();
        test_timeout_one();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ife_block_scheduler.md
Name: ife_block_scheduler

Overview:
Collects a serial instruction stream into blocks of BLOCK_SIZE and presents each block to ife_dependence_checker. Dispatches the block to the backend in one beat when the checker reports it safe, or one instruction per beat when it does not. Sits between the fetch queue and the expanded issue lanes, and owns the checker instance's inputs.

Parameters:
INSTR_WIDTH, 32, instruction width in bits
BLOCK_SIZE, 4, lanes per block (≥2)
FLUSH_TIMEOUT, 8, idle cycles with a partial block before forced dispatch (≥1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch instruction valid
in_instr  input  INSTR_WIDTH  fetch instruction
in_ready  output  1  scheduler accepts in_instr this cycle
flush  input  1  force dispatch of the partial block
chk_instrs  output  BLOCK_SIZE*INSTR_WIDTH  block to checker (lane i = slot i)
chk_valid  output  BLOCK_SIZE  slot-valid mask to checker
chk_is_safe  input  1  checker result (combinational from chk_*)
out_valid  output  1  dispatch beat valid
out_ready  input  1  backend accepts beat
out_instrs  output  BLOCK_SIZE*INSTR_WIDTH  dispatched lanes
out_lanes_valid  output  BLOCK_SIZE  valid lanes in beat
out_parallel  output  1  1 = whole-block beat, 0 = serial beat
busy  output  1  buffer non-empty or dispatch in progress

Behaviour:
- Reset (async, rst_n low): state FILL, cnt=0, idle=0, ptr=0, buffer/mask cleared. While rst_n is low: in_ready=0, out_valid=0, out_lanes_valid=0, out_parallel=0, busy=0, chk_valid=0. in_ready is gated with rst_n.
- Reset mid-operation discards the buffered block; nothing is dispatched.
- Internal state: buffer slots 0..BLOCK_SIZE-1 filled contiguously from slot 0; cnt width $clog2(BLOCK_SIZE+1); saturating idle counter.
- chk_instrs = buffer and chk_valid = slot mask, driven from registers in all states.
- FILL:
  - in_ready=1. When in_valid, in_instr is written to slot cnt and cnt increments; idle clears.
  - A cycle with no accept and cnt>0 increments idle.
  - Go to CHECK when any of these holds:
    - the accept fills slot BLOCK_SIZE-1;
    - flush=1 and (cnt>0 or accept this cycle);
    - idle reaches FLUSH_TIMEOUT-1 and no accept occurs.
  - If accept and flush coincide, the new instruction is included in the block.
  - flush with an empty buffer is ignored.
- CHECK (one cycle):
  - in_ready=0.
  - chk_is_safe is registered into the mode bit.
  - Next state is PAR if safe, SER otherwise; ptr=0.
- PAR:
  - out_valid=1, out_instrs=buffer, out_lanes_valid=slot mask, out_parallel=1.
  - On out_ready, clear buffer, mask, cnt and idle; go to FILL.
- SER:
  - out_valid=1, out_instrs lane0=slot[ptr], other lanes 0, out_lanes_valid=...0001, out_parallel=0.
  - On out_ready: if ptr==cnt-1, clear and go to FILL; otherwise ptr++.
- Handshake:
  - Once out_valid is high, out_* stay stable until out_ready.
  - out_valid never drops without a handshake except on reset.
  - in_* are accepted only in FILL.
- Latency: last accept at cycle T → CHECK at T+1 → out_valid at T+2. A serial block of n instructions needs n handshakes.
- busy = (state≠FILL) or (cnt≠0).
- Timeout boundary: FLUSH_TIMEOUT=1 dispatches after one idle cycle.

Test Plan:
- Independent full block: 0x003100B3, 0x00628233, 0x009403B3, 0x00C58533 (add x1/x4/x7/x10) on consecutive cycles, out_ready=1 → out_valid at T+2, out_parallel=1, out_lanes_valid=1111, one beat, then in_ready=1.
- RAW block: 0x003100B3, 0x002082B3 (add x5,x1,x2), 0x009403B3, 0x00C58533 → four serial beats; lane0 carries the instructions in order; out_lanes_valid=0001; out_parallel=0.
- Partial + flush: two independent instructions, then flush=1 → single parallel beat with out_lanes_valid=0011. Flush with empty buffer → no beat, busy=0.
- Timeout: one instruction then in_valid=0, FLUSH_TIMEOUT=8 → beat dispatched with out_lanes_valid=0001; no beat before the timeout expires.
- Backpressure: out_ready=0 for 5 cycles in PAR and in SER → out_* held stable and in_ready=0; resumes correctly when out_ready=1.
- Reset mid-SER: rst_n low after the second serial beat → out_valid=0 and busy=0 immediately; the next block after reset dispatches normally.
